// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a five-state multi-cycle MIPS datapath (IF/ID/EX/MEM/WB).
// Optional memory handshake: define CTRL_MEM_WAIT_EN to add MemReady and stall IF/MEM.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [2:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
  } ctrl_t;

  state_e stateQ, stateD;
  ctrl_t  ctrlQ, ctrlLive;
  logic   memOk;
  logic   unusedZero;

  // Branch resolution happens in the datapath; Zero is only part of the bus.
  assign unusedZero = Zero;

`ifdef CTRL_MEM_WAIT_EN
  assign memOk = MemReady;
`else
  assign memOk = 1'b1;
`endif

  // Control word a state presents; OpCode/Funct only matter from ID onward.
  function automatic ctrl_t ctrlFor(state_e s, logic [5:0] op, logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.memRead = 1'b1;
        c.irWrite = 1'b1;
        c.pcWrite = 1'b1;
        c.aluSrcB = 2'b01;
      end
      S_ID: c.aluSrcB = 2'b11;
      S_EX: begin
        case (op)
          OP_LW, OP_SW, OP_ADDI: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = 2'b10;
          end
          OP_RTYPE: begin
            if (fn == FN_JR) begin
              c.pcWrite  = 1'b1;
              c.pcSource = 2'b11;
            end else begin
              c.aluSrcA = 1'b1;
              c.aluOp   = 2'b10;
            end
          end
          OP_BEQ: begin
            c.aluSrcA     = 1'b1;
            c.aluOp       = 2'b01;
            c.pcWriteCond = 1'b1;
            c.pcSource    = 2'b01;
          end
          OP_J: begin
            c.pcWrite  = 1'b1;
            c.pcSource = 2'b10;
          end
          OP_JAL: begin
            c.pcWrite  = 1'b1;
            c.pcSource = 2'b10;
            c.regWrite = 1'b1;
            c.regDst   = 2'b10;
            c.memtoReg = 2'b10;
          end
          default: c = '0;
        endcase
      end
      S_MEM: begin
        c.iorD     = 1'b1;
        c.memRead  = (op == OP_LW);
        c.memWrite = (op == OP_SW);
      end
      S_WB: begin
        c.regWrite = 1'b1;
        if (op == OP_RTYPE) c.regDst = 2'b01;
        if (op == OP_LW) c.memtoReg = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    stateD = S_IF;
    case (stateQ)
      S_IF: stateD = memOk ? S_ID : S_IF;
      S_ID: stateD = S_EX;
      S_EX: begin
        if (OpCode == OP_LW || OpCode == OP_SW)
          stateD = S_MEM;
        else if ((OpCode == OP_RTYPE && Funct != FN_JR) || OpCode == OP_ADDI)
          stateD = S_WB;
        else
          stateD = S_IF;
      end
      S_MEM: begin
        if (!memOk)
          stateD = S_MEM;
        else if (OpCode == OP_LW)
          stateD = S_WB;
        else
          stateD = S_IF;
      end
      S_WB:    stateD = S_IF;
      default: stateD = S_IF;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with State.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ <= S_IF;
      ctrlQ  <= ctrlFor(S_IF, 6'h00, 6'h00);
    end else begin
      stateQ <= stateD;
      ctrlQ  <= ctrlFor(stateD, OpCode, Funct);
    end
  end

  assign ctrlLive = reset ? ctrlQ : '0;

  // PC advances in IF only on the cycle the fetch completes.
  assign PCWrite     = ctrlLive.pcWrite & ((stateQ != S_IF) | memOk);
  assign PCWriteCond = ctrlLive.pcWriteCond;
  assign IorD        = ctrlLive.iorD;
  assign MemRead     = ctrlLive.memRead;
  assign MemWrite    = ctrlLive.memWrite;
  assign IRWrite     = ctrlLive.irWrite;
  assign RegWrite    = ctrlLive.regWrite;
  assign ALUSrcA     = ctrlLive.aluSrcA;
  assign RegDst      = ctrlLive.regDst;
  assign MemtoReg    = ctrlLive.memtoReg;
  assign ALUSrcB     = ctrlLive.aluSrcB;
  assign PCSource    = ctrlLive.pcSource;
  assign ALUOp       = ctrlLive.aluOp;
  assign State       = stateQ;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction scenarios plus randomized streams
// checked against an instruction-class reference model. Covers CTRL_MEM_WAIT_EN when defined.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
`ifdef CTRL_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp;
  logic [2:0] State;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .Zero       (Zero),
`ifdef CTRL_MEM_WAIT_EN
    .MemReady   (MemReady),
`endif
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .State      (State)
  );

  typedef enum {C_R, C_JR, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ADDI, C_NOP} cls_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp};

  function automatic cls_e classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h08) ? C_JR : C_R;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      6'h08:   return C_ADDI;
      default: return C_NOP;
    endcase
  endfunction

  function automatic int instrLen(cls_e c);
    if (c == C_LW) return 5;
    if (c == C_R || c == C_ADDI || c == C_SW) return 4;
    return 3;
  endfunction

  // Cycle i of an instruction: IF, ID, EX always; then MEM and/or WB by class.
  function automatic int expState(cls_e c, int i);
    if (i < 3) return i;
    if (c == C_SW) return 3;
    if (c == C_LW) return i;
    return 4;
  endfunction

  function automatic ctrl_t expCtrl(int st, cls_e c);
    ctrl_t e;
    e = '0;
    if (st == 0) begin
      e.memRead = 1'b1; e.irWrite = 1'b1; e.pcWrite = 1'b1; e.aluSrcB = 2'b01;
    end else if (st == 1) begin
      e.aluSrcB = 2'b11;
    end else if (st == 2) begin
      case (c)
        C_LW, C_SW, C_ADDI: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
        C_R:   begin e.aluSrcA = 1'b1; e.aluOp = 2'b10; end
        C_BEQ: begin e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcWriteCond = 1'b1; e.pcSource = 2'b01; end
        C_J:   begin e.pcWrite = 1'b1; e.pcSource = 2'b10; end
        C_JR:  begin e.pcWrite = 1'b1; e.pcSource = 2'b11; end
        C_JAL: begin
          e.pcWrite = 1'b1; e.pcSource = 2'b10; e.regWrite = 1'b1;
          e.regDst = 2'b10; e.memtoReg = 2'b10;
        end
        default: e = '0;
      endcase
    end else if (st == 3) begin
      e.iorD = 1'b1;
      e.memRead = (c == C_LW);
      e.memWrite = (c == C_SW);
    end else if (st == 4) begin
      e.regWrite = 1'b1;
      if (c == C_R) e.regDst = 2'b01;
      if (c == C_LW) e.memtoReg = 2'b01;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
    OpCode = op;
    Funct  = fn;
    Zero   = z;
  endtask

  // Runs one instruction starting in its IF cycle; junk opcode during IF must be ignored.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int maxCyc, input string tag);
    cls_e  c;
    int    n;
    ctrl_t e;
    c = classify(op, fn);
    n = instrLen(c);
    if (maxCyc < n) n = maxCyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) applyStimulus(6'($urandom), 6'($urandom), 1'($urandom));
      else applyStimulus(op, fn, z);
      #1;
      checks++;
      if (State !== 3'(expState(c, i))) begin
        failures++;
        $display("[TB] FAIL %s state cyc%0d: got %0d want %0d", tag, i, State, expState(c, i));
      end
      e = expCtrl(expState(c, i), c);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL %s ctrl cyc%0d: got %h want %h", tag, i, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(6'h23, 6'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (State !== 3'd0) begin
      failures++; $display("[TB] FAIL reset_state: got %0d want 0", State);
    end
    checks++;
    if (obs !== ctrl_t'('0)) begin
      failures++; $display("[TB] FAIL reset_forced_zero: got %h want 0", obs);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (State !== 3'd0 || obs !== expCtrl(0, C_NOP)) begin
      failures++;
      $display("[TB] FAIL reset_release_if: got state %0d ctrl %h want 0 %h", State, obs, expCtrl(0, C_NOP));
    end
  endtask

  task automatic test_rtype();   runInstr(6'h00, 6'h20, 1'b0, 99, "add");  endtask
  task automatic test_lw();      runInstr(6'h23, 6'h11, 1'b0, 99, "lw");   endtask
  task automatic test_sw();      runInstr(6'h2B, 6'h05, 1'b1, 99, "sw");   endtask
  task automatic test_addi();    runInstr(6'h08, 6'h3C, 1'b0, 99, "addi"); endtask
  task automatic test_jumps();
    runInstr(6'h02, 6'h00, 1'b0, 99, "j");
    runInstr(6'h03, 6'h00, 1'b0, 99, "jal");
    runInstr(6'h00, 6'h08, 1'b0, 99, "jr");
    runInstr(6'h3F, 6'h00, 1'b1, 99, "nop3f");
  endtask
  task automatic test_beq();
    runInstr(6'h04, 6'h00, 1'b1, 99, "beq_z1");
    runInstr(6'h04, 6'h00, 1'b0, 99, "beq_z0");
  endtask

  // Reset during lw's MEM cycle: strobes drop at once, next state is IF, no WB follows.
  task automatic test_reset_mid();
    runInstr(6'h23, 6'h00, 1'b0, 3, "lw_pre");
    @(negedge clk);
    #1;
    checks++;
    if (State !== 3'd3 || MemRead !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_mem_entry: got state %0d memread %b want 3 1", State, MemRead);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== ctrl_t'('0)) begin
      failures++; $display("[TB] FAIL mid_reset_zero: got %h want 0", obs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (State !== 3'd0) begin
      failures++; $display("[TB] FAIL mid_reset_state: got %0d want 0", State);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== expCtrl(0, C_NOP)) begin
      failures++; $display("[TB] FAIL mid_release_if: got %h want %h", obs, expCtrl(0, C_NOP));
    end
    runInstr(6'h00, 6'h22, 1'b0, 99, "after_mid");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8];
    logic [5:0] op, fn;
    int         pick;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08, 6'h00};
    for (int k = 0; k < 40; k++) begin
      pick = $urandom_range(0, 8);
      op = (pick == 8) ? 6'($urandom) : ops[pick];
      fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      runInstr(op, fn, 1'($urandom), 99, "rand");
    end
  endtask

`ifdef CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      pulses += int'(PCWrite);
      checks++;
      if (State !== 3'd0 || IRWrite !== 1'b1 || MemRead !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wait_hold: got state %0d ir %b mr %b want 0 1 1", State, IRWrite, MemRead);
      end
    end
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    pulses += int'(PCWrite);
    @(negedge clk);
    applyStimulus(6'h02, 6'h00, 1'b0);
    #1;
    checks++;
    if (State !== 3'd1) begin
      failures++; $display("[TB] FAIL wait_advance: got %0d want 1", State);
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("[TB] FAIL wait_pc_pulse: got %0d want 1", pulses);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
`ifdef CTRL_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_addi();
    test_beq();
    test_jumps();
    test_reset_mid();
    test_back_to_back();
`ifdef CTRL_MEM_WAIT_EN
    test_mem_wait();
    runInstr(6'h23, 6'h00, 1'b0, 99, "lw_after_wait");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
